// File: rtl/traffic_phase_controller_if.sv
// Bundles the sensor inputs and lamp outputs of traffic_phase_controller.
// The master side drives the sensors and reads the lamps; the slave side is the controller.
interface traffic_phase_controller_if #(
    parameter int NUM_LANES = 8,
    parameter int TIMER_W   = 7
);
    logic [4:0]           hoursIn;
    logic                 pedSignal;
    logic                 emgSignal;
    logic [NUM_LANES-1:0] emgLane;
    logic [NUM_LANES-1:0] laneDemand;
    logic [NUM_LANES-1:0] trafficLightOutput;
    logic [NUM_LANES-1:0] yellowOutput;
    logic                 walkOutput;
    logic [1:0]           trafficMode;
    logic [TIMER_W-1:0]   timerCount;

    modport master (
        output hoursIn, pedSignal, emgSignal, emgLane, laneDemand,
        input  trafficLightOutput, yellowOutput, walkOutput, trafficMode, timerCount
    );

    modport slave (
        input  hoursIn, pedSignal, emgSignal, emgLane, laneDemand,
        output trafficLightOutput, yellowOutput, walkOutput, trafficMode, timerCount
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: round-robin green rotation with day/night timing,
// yellow clearance, emergency preemption and an optional pedestrian walk phase.
// Optional feature macro: TRAFFIC_PED_EN (pedestrian request/walk logic).
// All lamp, mode and timer outputs come straight from flops.
module traffic_phase_controller #(
    parameter int NUM_LANES   = 8,
    parameter int TIMER_W     = 7,
    parameter int GREEN_DAY   = 30,
    parameter int GREEN_NIGHT = 10,
    parameter int YELLOW_TIME = 3,
    parameter int PED_TIME    = 20,
    parameter int EMG_TIME    = 15
) (
    input logic clk,
    input logic rst,
    traffic_phase_controller_if.slave bus
);
    localparam int LANE_W = $clog2(NUM_LANES);

    localparam logic [1:0] ST_GREEN    = 2'd0;
    localparam logic [1:0] ST_YELLOW   = 2'd1;
    localparam logic [1:0] ST_PED_WALK = 2'd2;
    localparam logic [1:0] ST_EMG      = 2'd3;

    localparam logic [1:0] MODE_DAY   = 2'd0;
    localparam logic [1:0] MODE_NIGHT = 2'd1;
    localparam logic [1:0] MODE_PED   = 2'd2;
    localparam logic [1:0] MODE_EMG   = 2'd3;

    localparam logic [TIMER_W-1:0] T_GREEN_DAY   = TIMER_W'(GREEN_DAY - 1);
    localparam logic [TIMER_W-1:0] T_GREEN_NIGHT = TIMER_W'(GREEN_NIGHT - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW      = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_PED         = TIMER_W'(PED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_EMG         = TIMER_W'(EMG_TIME - 1);

    logic [1:0]           state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [LANE_W-1:0]    next_lane_q, next_lane_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           mode_q, mode_d;
    logic                 from_emg_q, from_emg_d;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic [NUM_LANES-1:0] yellow_q, yellow_d;

    logic                 night_now;
    logic                 emg_valid;
    logic [LANE_W-1:0]    emg_low;
    logic                 dem_found;
    logic [LANE_W-1:0]    dem_lane;
    logic [LANE_W-1:0]    lane_plus1;
    logic                 ped_pending;
    logic                 enter_green;
    logic [LANE_W-1:0]    green_lane;

    assign night_now  = (bus.hoursIn < 5'd6) || (bus.hoursIn >= 5'd20);
    assign emg_valid  = bus.emgSignal && (|bus.emgLane);
    assign lane_plus1 = (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + LANE_W'(1);

    // Lowest-indexed lane requested by the emergency vehicle.
    always_comb begin
        emg_low = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (bus.emgLane[i]) emg_low = LANE_W'(i);
        end
    end

    // First lane after the current one, in round-robin order, that has vehicle demand.
    always_comb begin
        int idx;
        idx       = 0;
        dem_found = 1'b0;
        dem_lane  = lane_q;
        for (int j = NUM_LANES - 1; j >= 1; j--) begin
            idx = (int'(lane_q) + j) % NUM_LANES;
            if (bus.laneDemand[idx]) begin
                dem_found = 1'b1;
                dem_lane  = LANE_W'(idx);
            end
        end
    end

    // Phase sequencing; an emergency request overrides every other decision.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        next_lane_d = next_lane_q;
        mode_d      = mode_q;
        from_emg_d  = from_emg_q;
        timer_d     = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
        enter_green = 1'b0;
        green_lane  = next_lane_q;
        if (emg_valid) begin
            state_d = ST_EMG;
            lane_d  = emg_low;
            mode_d  = MODE_EMG;
            if (state_q != ST_EMG) timer_d = T_EMG;
        end else begin
            case (state_q)
                ST_GREEN: begin
                    if (timer_q == '0) begin
                        if (mode_q == MODE_NIGHT || dem_found || ped_pending) begin
                            state_d     = ST_YELLOW;
                            timer_d     = T_YELLOW;
                            from_emg_d  = 1'b0;
                            if (mode_q == MODE_NIGHT) next_lane_d = lane_plus1;
                            else if (dem_found)       next_lane_d = dem_lane;
                            else                      next_lane_d = lane_q;
                        end else begin
                            enter_green = 1'b1;
                            green_lane  = lane_q;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (timer_q == '0) begin
                        if (ped_pending && !from_emg_q) begin
                            state_d = ST_PED_WALK;
                            timer_d = T_PED;
                            mode_d  = MODE_PED;
                        end else begin
                            enter_green = 1'b1;
                        end
                    end
                end
                ST_PED_WALK: begin
                    if (timer_q == '0) enter_green = 1'b1;
                end
                default: begin
                    state_d     = ST_YELLOW;
                    timer_d     = T_YELLOW;
                    from_emg_d  = 1'b1;
                    next_lane_d = (dem_found && !night_now) ? dem_lane : lane_plus1;
                end
            endcase
            if (enter_green) begin
                state_d = ST_GREEN;
                lane_d  = green_lane;
                mode_d  = night_now ? MODE_NIGHT : MODE_DAY;
                timer_d = night_now ? T_GREEN_NIGHT : T_GREEN_DAY;
            end
        end
    end

    // Lamp patterns for the upcoming phase, registered alongside the state.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        if (state_d == ST_GREEN || state_d == ST_EMG) green_d = NUM_LANES'(1) << lane_d;
        if (state_d == ST_YELLOW) yellow_d = NUM_LANES'(1) << lane_d;
    end

    // State, timer and lamp registers; reset abandons any phase straight into lane 0 green.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_GREEN;
            lane_q      <= '0;
            next_lane_q <= '0;
            timer_q     <= T_GREEN_DAY;
            mode_q      <= MODE_DAY;
            from_emg_q  <= 1'b0;
            green_q     <= NUM_LANES'(1);
            yellow_q    <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            next_lane_q <= next_lane_d;
            timer_q     <= timer_d;
            mode_q      <= mode_d;
            from_emg_q  <= from_emg_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    logic ped_pending_q, ped_pending_d;
    logic walk_q, walk_d;
    logic walk_done;

    assign walk_done = (state_q == ST_PED_WALK) && (timer_q == '0) && !emg_valid;

    // Pending pedestrian request: latched outside the walk phase, cleared when a walk completes.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_d        = (state_d == ST_PED_WALK);
        if (walk_done) ped_pending_d = 1'b0;
        else if (bus.pedSignal && state_q != ST_PED_WALK) ped_pending_d = 1'b1;
    end

    // Pedestrian flag and walk lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    assign ped_pending    = ped_pending_q;
    assign bus.walkOutput = walk_q;
`else
    assign ped_pending    = 1'b0;
    assign bus.walkOutput = 1'b0;
`endif

    assign bus.trafficLightOutput = green_q;
    assign bus.yellowOutput       = yellow_q;
    assign bus.trafficMode        = mode_q;
    assign bus.timerCount         = timer_q;

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 8, giving the number of controlled lanes (2..16).
REQ-002 The block SHALL have parameter TIMER_W, default 7, giving the phase timer width.
REQ-003 The block SHALL have parameters GREEN_DAY=30, GREEN_NIGHT=10, YELLOW_TIME=3, PED_TIME=20 and EMG_TIME=15, each a phase length in cycles (1..2^TIMER_W).
REQ-004 clk  in  1  one-second clock; the block has one clock and its reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 hoursIn  in  5  hour of day, 0..23.
REQ-007 pedSignal  in  1  pedestrian crossing request, level or pulse.
REQ-008 emgSignal  in  1  emergency preemption active.
REQ-009 emgLane  in  NUM_LANES  lane(s) requested by the emergency vehicle.
REQ-010 laneDemand  in  NUM_LANES  per-lane vehicle presence.
REQ-011 trafficLightOutput  out  NUM_LANES  green lamps, one-hot or zero.
REQ-012 yellowOutput  out  NUM_LANES  yellow lamps, one-hot or zero.
REQ-013 walkOutput  out  1  pedestrian walk lamp.
REQ-014 trafficMode  out  2  registered mode: 0=DAY, 1=NIGHT, 2=PED, 3=EMG.
REQ-015 timerCount  out  TIMER_W  remaining cycles in the current phase.

Function
REQ-016 The block SHALL implement the states GREEN, YELLOW, PED_WALK and EMG; every output SHALL be registered.
REQ-017 On entering a phase of length T, the timer SHALL load T-1 and decrement once per cycle, so that the phase lasts exactly T cycles; the exit transition SHALL occur on the cycle in which the timer is 0.
REQ-018 Night SHALL be hoursIn<6 or hoursIn>=20, and any hoursIn>23 SHALL be treated as night; the day/night choice SHALL be sampled only on entry to GREEN.
REQ-019 In DAY GREEN, the block SHALL select the next lane in round-robin order after the current lane whose laneDemand bit is 1, and the green phase length SHALL be GREEN_DAY.
REQ-020 In NIGHT GREEN, the block SHALL advance to lane (current+1) mod NUM_LANES without regard to demand, and the green phase length SHALL be GREEN_NIGHT.
REQ-021 In DAY, if no other lane has demand when the green ends, the current lane SHALL stay green and the timer SHALL reload without a YELLOW phase.
REQ-022 Every GREEN that is left for a different lane, for PED_WALK, or for an EMG release SHALL pass through YELLOW for the lane being left, lasting YELLOW_TIME cycles.
REQ-023 A pedSignal high for at least one cycle SHALL set a pending flag.
REQ-024 After the next YELLOW, the block SHALL enter PED_WALK for PED_TIME cycles with all greens at 0 and walkOutput at 1, then clear the pending flag and resume at the next lane.
REQ-025 A pedSignal that arrives during PED_WALK SHALL be ignored.
REQ-026 When emgSignal=1 and emgLane!=0, the block SHALL enter EMG on the next edge from any state, with the green on the lowest-indexed set bit of emgLane and yellow and walk at 0.
REQ-027 In EMG, the timer SHALL reload EMG_TIME-1 on entry and hold at 0 thereafter.
REQ-028 When emgSignal=1 and emgLane=0, the block SHALL ignore the emergency request.
REQ-029 An emgLane change during EMG SHALL move the green on the next edge.
REQ-030 On EMG release, the block SHALL perform YELLOW on the emergency lane and then resume in GREEN at the next lane in round-robin order; a pending pedestrian request SHALL be retained and served afterwards.
REQ-031 Priority SHALL be EMG > PED > normal rotation.
REQ-032 At most one bit SHALL be set across trafficLightOutput and yellowOutput combined, and walkOutput=1 SHALL imply that both are zero.

Reset
REQ-033 While rst=1, the block SHALL hold state GREEN, lane 0, trafficLightOutput=1, yellowOutput=0, walkOutput=0, trafficMode=0, timerCount=GREEN_DAY-1, and the pedestrian pending flag cleared.
REQ-034 An assertion of rst mid-phase, including during EMG, SHALL abandon the phase at the next edge with no yellow.

Configuration
REQ-035 The block SHALL support the macro TRAFFIC_PED_EN.
REQ-036 With TRAFFIC_PED_EN defined, the pedestrian logic SHALL be included and behave as specified in REQ-023 to REQ-025.
REQ-037 Without TRAFFIC_PED_EN, pedSignal SHALL be ignored, PED_WALK SHALL be unreachable, walkOutput SHALL be constant 0, and the pending flag logic SHALL be removed.

Verification
REQ-038 Day round-robin: hoursIn=12, laneDemand=8'b0000_1010, after reset -> lane0 green 30 cycles, yellow0 3 cycles, lane1 green 30 cycles, yellow1 3 cycles, lane3 green.
REQ-039 Sole demand hold: hoursIn=12, laneDemand=8'b0000_0001 -> lane0 green continuously, no yellow, timer reloads 29 every 30 cycles.
REQ-040 Night cycling: hoursIn=23, laneDemand=0 -> lanes 0,1,2,... each green 10 cycles separated by 3-cycle yellows, trafficMode=1; hoursIn=24 gives identical behaviour.
REQ-041 Pedestrian: 1-cycle pedSignal pulse at cycle 5 of lane0 green -> yellow0 at cycle 30, walkOutput=1 for 20 cycles, then next lane green; with TRAFFIC_PED_EN undefined -> no walk phase.
REQ-042 Emergency: during lane2 green, emgSignal=1 with emgLane=8'b0101_0000 -> lane4 green next edge, trafficMode=3; release -> yellow4 3 cycles, then next demanded lane green; emgLane=0 with emgSignal=1 -> no change.
REQ-043 Reset mid-EMG: assert rst during EMG -> next edge lane0 green, timerCount=29, all other outputs 0.
